// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller
//   IEEE 1149.1-style TAP for the edge-connector JTAG pins. Contains the
//   16-state TAP FSM, an IR_WIDTH instruction register and three data
//   registers: BYPASS, IDCODE and a USER register exported to core logic.
//
// Ports
//   Clock            TCK, all state changes on the rising edge
//   Reset            asynchronous, active-high; forces TestLogicReset
//   TestMode         TMS
//   DataInput        TDI
//   DataOutput       TDO, combinational LSB of the active shift register
//   DataOutputEnable high only in ShiftDR / ShiftIR
//   State            current TAP state (4-bit encoding below)
//   Instruction      active instruction
//   UserDataIn       value captured into the USER shift register
//   UserDataOut      last value updated into the USER register
//   UserUpdate       one-cycle strobe when UserDataOut is written
module jtag_tap_controller #(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int unsigned USER_WIDTH   = 16,
    parameter int unsigned INSTR_IDCODE = 1,
    parameter int unsigned INSTR_USER   = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  TestMode,
    input  logic                  DataInput,
    output logic                  DataOutput,
    output logic                  DataOutputEnable,
    output logic [3:0]            State,
    output logic [IR_WIDTH-1:0]   Instruction,
    input  logic [USER_WIDTH-1:0] UserDataIn,
    output logic [USER_WIDTH-1:0] UserDataOut,
    output logic                  UserUpdate
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    tap_state_t            state, state_next;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic [31:0]           idcode_shift;
    logic [USER_WIDTH-1:0] user_shift;
    logic                  bypass_shift;
    logic                  sel_idcode;
    logic                  sel_user;

    assign State      = state;
    assign sel_idcode = (Instruction == IR_IDCODE);
    assign sel_user   = (Instruction == IR_USER) && !sel_idcode;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= TLR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:    state_next = TestMode ? TLR    : RTI;
            RTI:    state_next = TestMode ? SEL_DR : RTI;
            SEL_DR: state_next = TestMode ? SEL_IR : CAP_DR;
            CAP_DR: state_next = TestMode ? EX1_DR : SH_DR;
            SH_DR:  state_next = TestMode ? EX1_DR : SH_DR;
            EX1_DR: state_next = TestMode ? UPD_DR : PAU_DR;
            PAU_DR: state_next = TestMode ? EX2_DR : PAU_DR;
            EX2_DR: state_next = TestMode ? UPD_DR : SH_DR;
            UPD_DR: state_next = TestMode ? SEL_DR : RTI;
            SEL_IR: state_next = TestMode ? TLR    : CAP_IR;
            CAP_IR: state_next = TestMode ? EX1_IR : SH_IR;
            SH_IR:  state_next = TestMode ? EX1_IR : SH_IR;
            EX1_IR: state_next = TestMode ? UPD_IR : PAU_IR;
            PAU_IR: state_next = TestMode ? EX2_IR : PAU_IR;
            EX2_IR: state_next = TestMode ? UPD_IR : SH_IR;
            UPD_IR: state_next = TestMode ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // Instruction register path
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir_shift    <= '0;
            Instruction <= IR_IDCODE;
        end else begin
            case (state)
                TLR:    Instruction <= IR_IDCODE;
                CAP_IR: ir_shift    <= IR_CAPTURE;
                SH_IR:  ir_shift    <= {DataInput, ir_shift[IR_WIDTH-1:1]};
                UPD_IR: Instruction <= ir_shift;
                default: ;
            endcase
        end
    end

    // Data register path; the USER shift is written with shift operators so
    // that USER_WIDTH = 1 elaborates without a reversed part-select.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_shift <= 1'b0;
        end else begin
            case (state)
                CAP_DR: begin
                    idcode_shift <= IDCODE_VALUE;
                    user_shift   <= UserDataIn;
                    bypass_shift <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode)
                        idcode_shift <= {DataInput, idcode_shift[31:1]};
                    else if (sel_user)
                        user_shift <= (user_shift >> 1)
                                    | (USER_WIDTH'(DataInput) << (USER_WIDTH - 1));
                    else
                        bypass_shift <= DataInput;
                end
                default: ;
            endcase
        end
    end

    // USER update register and strobe
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            UserDataOut <= '0;
            UserUpdate  <= 1'b0;
        end else begin
            UserUpdate <= (state == UPD_DR) && sel_user;
            if ((state == UPD_DR) && sel_user)
                UserDataOut <= user_shift;
        end
    end

    always_comb begin
        DataOutput       = 1'b0;
        DataOutputEnable = 1'b0;
        if (state == SH_IR) begin
            DataOutput       = ir_shift[0];
            DataOutputEnable = 1'b1;
        end else if (state == SH_DR) begin
            DataOutputEnable = 1'b1;
            if (sel_idcode)    DataOutput = idcode_shift[0];
            else if (sel_user) DataOutput = user_shift[0];
            else               DataOutput = bypass_shift;
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller
//   Self-checking bench for jtag_tap_controller. Expected TDO bits are pushed
//   into a scoreboard queue when the shift is planned and popped as the DUT
//   presents each bit during ShiftDR / ShiftIR.
module tb_jtag_tap_controller;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        TestMode = 1'b1;
    logic        DataInput = 1'b0;
    logic        DataOutput;
    logic        DataOutputEnable;
    logic [3:0]  State;
    logic [3:0]  Instruction;
    logic [15:0] UserDataIn = '0;
    logic [15:0] UserDataOut;
    logic        UserUpdate;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    jtag_tap_controller #(
        .IR_WIDTH    (4),
        .IDCODE_VALUE(32'h1000_0001),
        .USER_WIDTH  (16),
        .INSTR_IDCODE(1),
        .INSTR_USER  (2)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .TestMode        (TestMode),
        .DataInput       (DataInput),
        .DataOutput      (DataOutput),
        .DataOutputEnable(DataOutputEnable),
        .State           (State),
        .Instruction     (Instruction),
        .UserDataIn      (UserDataIn),
        .UserDataOut     (UserDataOut),
        .UserUpdate      (UserUpdate)
    );

    always #5 Clock = ~Clock;

    // Drive TMS/TDI for one rising edge; returns 1 time unit after the edge.
    task automatic step(input logic tms, input logic tdi);
        TestMode  = tms;
        DataInput = tdi;
        @(posedge Clock);
        #1;
    endtask

    // RTI -> shift value into IR -> UpdIR -> RTI
    task automatic load_ir(input logic [3:0] value);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, value[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // RTI -> SelDR -> CapDR -> ShDR
    task automatic enter_shdr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (State !== 4'd0 || Instruction !== 4'd1 || DataOutput !== 1'b0 ||
            DataOutputEnable !== 1'b0 || UserDataOut !== 16'h0 || UserUpdate !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: state=%0d ir=%0d tdo=%b oe=%b udo=%h upd=%b required 0 1 0 0 0000 0",
                     State, Instruction, DataOutput, DataOutputEnable, UserDataOut, UserUpdate);
        end
        Reset = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL reset_to_rti: state=%0d required 1", State);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] idv;
        logic        exp;
        int          bad;
        idv = 32'h1000_0001;
        bad = 0;
        enter_shdr();
        for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
        for (int i = 0; i < 32; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (DataOutput !== exp || DataOutputEnable !== 1'b1) begin
                errors++;
                $display("FAIL idcode_bit%0d: tdo=%b oe=%b required %b 1", i, DataOutput, DataOutputEnable, exp);
            end
            step(i == 31, 1'b0);
        end
        checks++;
        if (State !== 4'd5 || DataOutputEnable !== 1'b0) begin
            errors++;
            $display("FAIL idcode_exit: state=%0d oe=%b required 5 0", State, DataOutputEnable);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (State !== 4'd1 || UserUpdate !== 1'b0) begin
            errors++;
            $display("FAIL idcode_upd: state=%0d upd=%b required 1 0", State, UserUpdate);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] tdi;
        logic       exp;
        tdi = 4'b1101;      // sent 1,0,1,1 (index 0 first)
        load_ir(4'hF);
        checks++;
        if (Instruction !== 4'hF) begin
            errors++;
            $display("FAIL bypass_ir: ir=%h required f", Instruction);
        end
        enter_shdr();
        exp_q.push_back(1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(tdi[k]);
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (DataOutput !== exp) begin
                errors++;
                $display("FAIL bypass_bit%0d: tdo=%b required %b", k, DataOutput, exp);
            end
            step(k == 3, tdi[k]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (UserUpdate !== 1'b0 || UserDataOut !== 16'h0) begin
            errors++;
            $display("FAIL bypass_no_update: upd=%b udo=%h required 0 0000", UserUpdate, UserDataOut);
        end
    endtask

    task automatic test_user();
        logic [15:0] cap;
        logic [15:0] shin;
        logic        exp;
        cap  = 16'hBEEF;
        shin = 16'h1234;
        UserDataIn = cap;
        load_ir(4'h2);
        checks++;
        if (Instruction !== 4'h2) begin
            errors++;
            $display("FAIL user_ir: ir=%h required 2", Instruction);
        end
        enter_shdr();
        for (int i = 0; i < 16; i++) exp_q.push_back(cap[i]);
        UserDataIn = 16'h0;   // capture already taken; later changes must not matter
        for (int i = 0; i < 16; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (DataOutput !== exp) begin
                errors++;
                $display("FAIL user_bit%0d: tdo=%b required %b", i, DataOutput, exp);
            end
            step(i == 7 || i == 15, shin[i]);
            if (i == 7) begin
                // detour through PauseDR; shifting must resume where it stopped
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                checks++;
                if (State !== 4'd6 || DataOutputEnable !== 1'b0) begin
                    errors++;
                    $display("FAIL user_pause: state=%0d oe=%b required 6 0", State, DataOutputEnable);
                end
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0);
        checks++;
        if (State !== 4'd8 || UserUpdate !== 1'b0) begin
            errors++;
            $display("FAIL user_upd_state: state=%0d upd=%b required 8 0", State, UserUpdate);
        end
        step(1'b0, 1'b0);
        checks++;
        if (UserUpdate !== 1'b1 || UserDataOut !== shin) begin
            errors++;
            $display("FAIL user_update: upd=%b udo=%h required 1 %h", UserUpdate, UserDataOut, shin);
        end
        step(1'b0, 1'b0);
        checks++;
        if (UserUpdate !== 1'b0 || UserDataOut !== shin) begin
            errors++;
            $display("FAIL user_strobe_len: upd=%b udo=%h required 0 %h", UserUpdate, UserDataOut, shin);
        end
    endtask

    task automatic test_ir_capture_tlr();
        logic [3:0] capv;
        logic       exp;
        int         seen_upd;
        capv = 4'b0001;
        seen_upd = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(capv[i]);
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (DataOutput !== exp || DataOutputEnable !== 1'b1) begin
                errors++;
                $display("FAIL ircap_bit%0d: tdo=%b oe=%b required %b 1", i, DataOutput, DataOutputEnable, exp);
            end
            if (i < 3) step(1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            if (UserUpdate !== 1'b0) seen_upd++;
        end
        checks++;
        if (State !== 4'd0 || seen_upd != 0) begin
            errors++;
            $display("FAIL tms5_tlr: state=%0d upd_cycles=%0d required 0 0", State, seen_upd);
        end
        step(1'b1, 1'b0);
        checks++;
        if (Instruction !== 4'd1 || State !== 4'd0) begin
            errors++;
            $display("FAIL tlr_reload: ir=%0d state=%0d required 1 0", Instruction, State);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        UserDataIn = 16'hA5A5;
        load_ir(4'h2);
        enter_shdr();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (DataOutputEnable !== 1'b1 || UserDataOut !== 16'h1234) begin
            errors++;
            $display("FAIL pre_reset: oe=%b udo=%h required 1 1234", DataOutputEnable, UserDataOut);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || UserDataOut !== 16'h0 || DataOutputEnable !== 1'b0 ||
            DataOutput !== 1'b0 || Instruction !== 4'd1) begin
            errors++;
            $display("FAIL async_reset: state=%0d udo=%h oe=%b tdo=%b ir=%0d required 0 0000 0 0 1",
                     State, UserDataOut, DataOutputEnable, DataOutput, Instruction);
        end
        #1 Reset = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (UserUpdate !== 1'b0 || State !== 4'd1) begin
            errors++;
            $display("FAIL post_reset: upd=%b state=%0d required 0 1", UserUpdate, State);
        end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_user();
        test_ir_capture_tlr();
        test_reset_mid_shift();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- Parametrised IEEE 1149.1-style Test Access Port (TAP) for the GPU's edge-connector JTAG pins (A5–A8, B9). It replaces the earlier bare data pass-through.
- Implements the 16-state TAP FSM, an instruction register of configurable width, and three data registers: BYPASS, IDCODE and a USER register.
- The USER register is exposed to GPU core logic for debug access.
- Sits between the PCIe edge pins and internal debug/config logic.

Parameters:
- IR_WIDTH, 4, instruction register width, minimum 2.
- IDCODE_VALUE, 32'h1000_0001, value shifted out by IDCODE; bit 0 must be 1.
- USER_WIDTH, 16, USER data register width, minimum 1.
- INSTR_IDCODE, 1, IR code selecting IDCODE.
- INSTR_USER, 2, IR code selecting USER.

Ports:
- Clock, in, 1: JTAG clock (TCK). Single clock domain; all state changes on the rising edge.
- Reset, in, 1: asynchronous, active-high. Forces the FSM to TestLogicReset.
- TestMode, in, 1: TMS, sampled on the rising edge of Clock.
- DataInput, in, 1: TDI.
- DataOutput, out, 1: TDO.
- DataOutputEnable, out, 1: high only in ShiftDR/ShiftIR.
- State, out, 4: current TAP state, encoded as listed in Behaviour.
- Instruction, out, IR_WIDTH: active instruction.
- UserDataIn, in, USER_WIDTH: value captured into the USER shift register.
- UserDataOut, out, USER_WIDTH: last value updated into the USER register.
- UserUpdate, out, 1: one-cycle strobe when UserDataOut is written.

Behaviour:
- Clock/reset convention:
  - One clock; Reset is asynchronous and active-high.
  - Everything is rising-edge registered except the combinational DataOutput/DataOutputEnable decode.
- Reset values:
  - State=TestLogicReset(0), Instruction=INSTR_IDCODE, UserDataOut=0, UserUpdate=0.
  - All shift registers 0; DataOutput=0; DataOutputEnable=0.
- State encoding (State[3:0], by value):
  - 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauDR, 7 Ex2DR.
  - 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauIR, 14 Ex2IR, 15 UpdIR.
- Transitions (next state for TMS=0 / TMS=1):
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - SelIR: CapIR / TLR.
  - CapX: ShX / Ex1X.
  - ShX: ShX / Ex1X.
  - Ex1X: PauX / UpdX.
  - PauX: PauX / Ex2X.
  - Ex2X: ShX / UpdX.
  - UpdX: RTI / SelDR.
  - X = DR or IR.
- Five consecutive TMS=1 clocks reach TLR from any state.
- Each rising edge in TLR reloads Instruction=INSTR_IDCODE.
- IR path:
  - CapIR edge: ir_shift <= {zeros, 2'b01}.
  - Each ShIR edge: ir_shift <= {DataInput, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR edge: Instruction <= ir_shift. The new instruction is effective from the next cycle.
- DR selection by Instruction:
  - INSTR_IDCODE → 32-bit IDCODE register.
  - INSTR_USER → USER register.
  - Any other code, including all-ones → 1-bit BYPASS.
- DR path:
  - CapDR edge: IDCODE shift <= IDCODE_VALUE; USER shift <= UserDataIn; BYPASS <= 0.
  - Each ShDR edge: the selected register shifts right, with DataInput entering the MSB.
  - UpdDR edge with USER selected: UserDataOut <= USER shift, and UserUpdate=1 for exactly that following cycle. No UserUpdate for other instructions.
- DataOutput:
  - Combinational LSB of the IR shift register (in ShIR) or of the selected DR shift register (in ShDR); 0 otherwise.
  - Consequently bit 0 is visible in the first ShX cycle, before any shift edge.
- Pause states and Exit states hold the shift contents. Re-entering ShX via Ex2X continues from where shifting stopped.
- Reset asserted mid-shift:
  - Immediate return to reset values.
  - UserDataOut is cleared, and no UserUpdate strobe is generated.

Test Plan:
- Reset pulse, then TMS=0 → State 0 then 1; Instruction=1; DataOutput=0, DataOutputEnable=0.
- From RTI: TMS 1,0,0, then 32 ShDR clocks with DataInput=0 → DataOutput sequence LSB-first equals 32'h1000_0001; DataOutputEnable=1 throughout.
- Load IR=4'hF (BYPASS) via UpdIR; in ShDR send DataInput 1,0,1,1 → DataOutput 0,1,0,1 (one-cycle delay, captured 0 first).
- Load IR=2 with UserDataIn=16'hBEEF; shift in 16'h1234 → DataOutput streams 16'hBEEF LSB-first; after UpdDR, UserDataOut=16'h1234 and UserUpdate high exactly one cycle.
- In ShIR with IR=2: first DataOutput bits read 1,0,0,0 (capture pattern); then TMS=1 for five clocks → State=0, Instruction=1, no UserUpdate.
- Assert Reset mid-ShDR of USER → State=0, UserDataOut=0, DataOutputEnable=0 asynchronously, before the next Clock edge.
